// File: rtl/bio.sv
// Board I/O bus responder: LEDs, eight 7-segment digits, synchronized slide
// switches and debounced push keys with sticky press flags and an interrupt.
// Register map (addr = bus_addr[3:2]):
//   0: [26:18] led_g, [17:0] led_r
//   1: digits hex3..hex0, one per byte, bits [6:0] of each byte, 1 = segment lit
//   2: digits hex7..hex4, same layout
//   3: [31] ien, [23:21] press flags (write 1 to clear), [20:18] debounced keys,
//      [17:0] synchronized switches
module bio #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_BITS   = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq,
    output logic [8:0]  led_g,
    output logic [17:0] led_r,
    output logic [6:0]  hex7_n,
    output logic [6:0]  hex6_n,
    output logic [6:0]  hex5_n,
    output logic [6:0]  hex4_n,
    output logic [6:0]  hex3_n,
    output logic [6:0]  hex2_n,
    output logic [6:0]  hex1_n,
    output logic [6:0]  hex0_n,
    input  logic        key3_n,
    input  logic        key2_n,
    input  logic        key1_n,
    input  logic [17:0] sw
);

    localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CYCLES - 1);
    localparam logic [DEB_BITS-1:0] DEB_ONE  = DEB_BITS'(1);

    logic [8:0]                 led_g_q;
    logic [17:0]                led_r_q;
    logic [7:0][6:0]            hex_q;
    logic                       ien;
    logic [2:0]                 flags;
    logic [2:0]                 deb;
    logic [2:0]                 deb_next;
    logic [2:0]                 rise;
    logic [2:0][DEB_BITS-1:0]   cnt;
    logic [2:0][DEB_BITS-1:0]   cnt_next;
    logic [17:0]                sw_s1, sw_s2;
    logic [2:0]                 key_s1, key_s2;
    logic [2:0]                 clr;
    logic                       wr;

    // A write lands on the edge that ends the ack cycle.
    assign wr  = stb & we & ack;
    assign clr = (wr && addr == 2'd3) ? data_in[23:21] : 3'b000;

    // Responder handshake: ack on every second cycle of a held strobe.
    always_ff @(posedge clk) begin
        if (rst) ack <= 1'b0;
        else     ack <= stb & ~ack;
    end

    // Two-flop synchronizers; keys are inverted so 1 = pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            key_s1 <= ~{key3_n, key2_n, key1_n};
            key_s2 <= key_s1;
        end
    end

    // Debounce: count consecutive cycles the synchronized level disagrees with
    // the debounced state; toggle once the disagreement has lasted DEB_CYCLES.
    always_comb begin
        deb_next = deb;
        cnt_next = cnt;
        rise     = '0;
        for (int i = 0; i < 3; i++) begin
            if (key_s2[i] == deb[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == DEB_LAST) begin
                deb_next[i] = ~deb[i];
                cnt_next[i] = '0;
                rise[i]     = key_s2[i];
            end else begin
                cnt_next[i] = cnt[i] + DEB_ONE;
            end
        end
    end

    // Debounce state, counters and sticky press flags (a new press beats a clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            deb   <= '0;
            cnt   <= '0;
            flags <= '0;
        end else begin
            deb   <= deb_next;
            cnt   <= cnt_next;
            flags <= (flags & ~clr) | rise;
        end
    end

    // CPU-writable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_g_q <= '0;
            led_r_q <= '0;
            hex_q   <= '0;
            ien     <= 1'b0;
        end else if (wr) begin
            case (addr)
                2'd0: begin
                    led_g_q <= data_in[26:18];
                    led_r_q <= data_in[17:0];
                end
                2'd1: begin
                    hex_q[3] <= data_in[30:24];
                    hex_q[2] <= data_in[22:16];
                    hex_q[1] <= data_in[14:8];
                    hex_q[0] <= data_in[6:0];
                end
                2'd2: begin
                    hex_q[7] <= data_in[30:24];
                    hex_q[6] <= data_in[22:16];
                    hex_q[5] <= data_in[14:8];
                    hex_q[4] <= data_in[6:0];
                end
                default: ien <= data_in[31];
            endcase
        end
    end

    // Read mux is purely combinational on addr; the initiator samples it under ack.
    always_comb begin
        data_out = '0;
        case (addr)
            2'd0:    data_out = {5'b0, led_g_q, led_r_q};
            2'd1:    data_out = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
            2'd2:    data_out = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
            default: data_out = {ien, 7'b0, flags, deb, sw_s2};
        endcase
    end

    assign irq    = ien & (|flags);
    assign led_g  = led_g_q;
    assign led_r  = led_r_q;
    assign hex0_n = ~hex_q[0];
    assign hex1_n = ~hex_q[1];
    assign hex2_n = ~hex_q[2];
    assign hex3_n = ~hex_q[3];
    assign hex4_n = ~hex_q[4];
    assign hex5_n = ~hex_q[5];
    assign hex6_n = ~hex_q[6];
    assign hex7_n = ~hex_q[7];

endmodule

// File: tb/tb_bio.sv
// Self-checking bench for bio: directed scenarios plus randomized register
// traffic, with read data checked through a scoreboard queue.
module tb_bio;

    localparam int DEB_CYCLES = 4;
    localparam int DEB_BITS   = 3;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic        irq;
    logic [8:0]  led_g;
    logic [17:0] led_r;
    logic [6:0]  hex7_n, hex6_n, hex5_n, hex4_n, hex3_n, hex2_n, hex1_n, hex0_n;
    logic        key3_n, key2_n, key1_n;
    logic [17:0] sw;

    bio #(.DEB_CYCLES(DEB_CYCLES), .DEB_BITS(DEB_BITS)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq),
        .led_g(led_g), .led_r(led_r),
        .hex7_n(hex7_n), .hex6_n(hex6_n), .hex5_n(hex5_n), .hex4_n(hex4_n),
        .hex3_n(hex3_n), .hex2_n(hex2_n), .hex1_n(hex1_n), .hex0_n(hex0_n),
        .key3_n(key3_n), .key2_n(key2_n), .key1_n(key1_n), .sw(sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    // Reference model of the programmer-visible state.
    logic [8:0]  m_led_g;
    logic [17:0] m_led_r;
    logic [6:0]  m_hex [8];
    logic        m_ien;
    logic [2:0]  m_flags;
    logic [2:0]  m_deb;
    logic [17:0] m_sw;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_reg(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r = {5'b0, m_led_g, m_led_r};
            2'd1: for (int k = 0; k < 4; k++) r[8*k +: 7] = m_hex[k];
            2'd2: for (int k = 0; k < 4; k++) r[8*k +: 7] = m_hex[4+k];
            default: r = {m_ien, 7'b0, m_flags, m_deb, m_sw};
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_led_g = '0;
        m_led_r = '0;
        for (int k = 0; k < 8; k++) m_hex[k] = '0;
        m_ien   = 1'b0;
        m_flags = '0;
        m_deb   = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs();
        logic [6:0] dh [8];
        logic [6:0] e7;
        logic       eirq;
        dh = '{hex0_n, hex1_n, hex2_n, hex3_n, hex4_n, hex5_n, hex6_n, hex7_n};
        check("led_g", led_g, m_led_g);
        check("led_r", led_r, m_led_r);
        for (int k = 0; k < 8; k++) begin
            e7 = ~m_hex[k];
            check($sformatf("hex%0d_n", k), dh[k], e7);
        end
        eirq = m_ien & (|m_flags);
        check("irq", irq, eirq);
    endtask

    // One bus transfer, started just after a rising edge; returns just after
    // the edge that completes it.
    task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d);
        int n;
        n = 0;
        stb = 1'b1; we = w; addr = a; data_in = d;
        @(negedge clk);
        while (!ack && n < 8) begin
            n++;
            @(negedge clk);
        end
        check("ack_latency", n, 1);
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        xfer(1'b1, a, d);
        case (a)
            2'd0: begin m_led_g = d[26:18]; m_led_r = d[17:0]; end
            2'd1: for (int k = 0; k < 4; k++) m_hex[k]   = d[8*k +: 7];
            2'd2: for (int k = 0; k < 4; k++) m_hex[4+k] = d[8*k +: 7];
            default: begin m_flags = m_flags & ~d[23:21]; m_ien = d[31]; end
        endcase
    endtask

    task automatic rd(input logic [1:0] a);
        exp_q.push_back(exp_reg(a));
        xfer(1'b0, a, 32'h0);
    endtask

    // Monitor: every acknowledged read is checked against the next queued expectation.
    always @(negedge clk) begin
        if (stb && ack && !we && !rst) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read_unexpected: got %0h with empty scoreboard", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_data", data_out, mon_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        key3_n = 1'b1; key2_n = 1'b1; key1_n = 1'b1; sw = '0;
        model_reset();
        m_sw = '0;
        step(3);
        rst = 1'b0;
        step(3);

        // Reset state
        check_outputs();
        check("hex0_blank", hex0_n, 7'h7F);
        for (int a = 0; a < 4; a++) rd(2'(a));

        // LEDs and digits
        wr(2'd0, 32'h07FC0001);
        check_outputs();
        check("led_g_all", led_g, 9'h1FF);
        rd(2'd0);
        wr(2'd1, 32'h7F063F00);
        wr(2'd2, 32'h00007F00);
        check_outputs();
        check("hex3_lit", hex3_n, 7'h00);
        check("hex2_one", hex2_n, 7'h79);
        check("hex1_zero", hex1_n, 7'h40);
        check("hex5_lit", hex5_n, 7'h00);
        rd(2'd1);
        rd(2'd2);

        // Switch synchronizer latency and read-only bits
        sw = 18'h2A5A5;
        addr = 2'd3;
        @(negedge clk);
        check("sw_sync_c1", data_out[17:0], 18'h0);
        @(negedge clk);
        check("sw_sync_c2", data_out[17:0], 18'h0);
        @(negedge clk);
        check("sw_sync_c3", data_out[17:0], 18'h2A5A5);
        step(1);
        m_sw = sw;
        wr(2'd3, 32'h00040000);
        rd(2'd3);

        // Key1: glitch, real press, interrupt enable and clear
        key1_n = 1'b0;
        step(DEB_CYCLES - 1);
        key1_n = 1'b1;
        step(10);
        rd(2'd3);
        check_outputs();
        key1_n = 1'b0;
        step(10);
        m_deb[0] = 1'b1;
        m_flags[0] = 1'b1;
        rd(2'd3);
        check_outputs();
        wr(2'd3, 32'h80000000);
        check_outputs();
        check("irq_enabled", irq, 1'b1);
        wr(2'd3, 32'h80200000);
        check_outputs();
        rd(2'd3);
        key1_n = 1'b1;
        step(10);
        m_deb[0] = 1'b0;
        rd(2'd3);

        // Key2: press lands on the same edge as a write-1-clear of its flag
        key2_n = 1'b0;
        step(DEB_CYCLES);
        wr(2'd3, 32'h80400000);
        m_deb[1] = 1'b1;
        m_flags[1] = 1'b1;
        check_outputs();
        check("irq_set_wins", irq, 1'b1);
        rd(2'd3);
        key2_n = 1'b1;
        step(10);
        m_deb[1] = 1'b0;
        rd(2'd3);

        // Reset in the first cycle of a held write
        stb = 1'b1; we = 1'b1; addr = 2'd0; data_in = 32'h00012345; rst = 1'b1;
        @(negedge clk);
        check("ack_rst_first", ack, 1'b0);
        @(posedge clk);
        #1;
        model_reset();
        check("ack_rst_cycle", ack, 1'b0);
        check_outputs();
        rst = 1'b0; stb = 1'b0; we = 1'b0;
        step(4);
        rd(2'd0);
        rd(2'd3);
        wr(2'd0, 32'h05512345);
        check_outputs();
        rd(2'd0);

        // Randomized traffic with key3 held so flag clears matter
        key3_n = 1'b0;
        step(10);
        m_deb[2] = 1'b1;
        m_flags[2] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: wr(2'd0, $urandom);
                1: wr(2'd1, $urandom);
                2: wr(2'd2, $urandom);
                3: wr(2'd3, $urandom);
                4: begin
                    sw = 18'($urandom);
                    step(3);
                    m_sw = sw;
                end
                default: rd(2'($urandom_range(0, 3)));
            endcase
            check_outputs();
        end
        for (int a = 0; a < 4; a++) rd(2'(a));

        step(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
